// File: rtl/onehot_mux_pkg.sv
// Shared defaults for the pipelined one-hot mux: widths, channel count and
// the channel grouping used by the first-stage OR-reduction.
package onehot_mux_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_ERR_CNT_W = 16;
  localparam int GROUP_SZ      = 4;

  // Number of first-stage groups; the last group may be partial.
  function automatic int num_groups(input int num_ch);
    return (num_ch + GROUP_SZ - 1) / GROUP_SZ;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Classifies a select vector as one-hot, all-zero, or (implicitly) multi-hot.
module onehot_check #(
  parameter int NUM_CH = 16
) (
  input  logic [NUM_CH-1:0] sel_i,
  output logic              is_onehot,
  output logic              is_zero
);

  localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] low_cleared;

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  assign low_cleared = sel_i & (sel_i - ONE);
  assign is_zero     = ~|sel_i;
  assign is_onehot   = !is_zero && (low_cleared == '0);

endmodule

// File: rtl/pipelined_onehot_mux.sv
// Two-stage pipelined one-hot multiplexer with invalid-select detection.
// The saturating error counter is built only with PIPELINED_ONEHOT_MUX_ERR_CNT_EN.
module pipelined_onehot_mux
  import onehot_mux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        mux_sel,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     out_err,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  input  logic                     err_cnt_clr
);

  localparam int NG = num_groups(NUM_CH);

  // Handshake: a beat moves on an edge where valid and ready are both 1; the
  // source holds data stable while valid=1 and ready=0. The whole pipe moves
  // together whenever the output slot is empty or being drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic sel_onehot, sel_zero, sel_bad;

  onehot_check #(.NUM_CH(NUM_CH)) u_check (
    .sel_i     (mux_sel),
    .is_onehot (sel_onehot),
    .is_zero   (sel_zero)
  );

  assign sel_bad = sel_zero || !sel_onehot;

  logic [NG-1:0][DATA_W-1:0] grp_or_d;

  always_comb begin
    grp_or_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mux_sel[k]) begin
        grp_or_d[k / GROUP_SZ] = grp_or_d[k / GROUP_SZ] | data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  logic                      s1_valid_q, s1_err_q;
  logic [NG-1:0][DATA_W-1:0] s1_grp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_grp_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_err_q   <= sel_bad;
      s1_grp_q   <= grp_or_d;
    end
  end

  logic [DATA_W-1:0] fin_or;
  logic [DATA_W-1:0] s2_data_d, s2_data_q;
  logic              s2_valid_d, s2_valid_q;
  logic              s2_err_d, s2_err_q;

  // Invalid selects and empty slots carry zero data so the outputs need no gating.
  always_comb begin
    fin_or = '0;
    for (int g = 0; g < NG; g++) begin
      fin_or = fin_or | s1_grp_q[g];
    end
    s2_valid_d = s1_valid_q;
    s2_err_d   = s1_valid_q && s1_err_q;
    s2_data_d  = (s1_valid_q && !s1_err_q) ? fin_or : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_data_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s2_valid_d;
      s2_err_q   <= s2_err_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_err   = s2_err_q;
  assign data_out  = s2_data_q;

`ifdef PIPELINED_ONEHOT_MUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  // Clear wins over a same-cycle increment; the count sticks at all ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (in_valid && in_ready && sel_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_pipelined_onehot_mux.sv
// Directed and randomized checks of pipelined_onehot_mux against a queue-based
// reference; a second instance with a 2-bit counter exercises saturation.
module tb_pipelined_onehot_mux;

`ifdef PIPELINED_ONEHOT_MUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready, in_ready_s;
  logic [15:0]   mux_sel;
  logic [511:0]  data_in;
  logic          out_valid, out_valid_s;
  logic          out_ready;
  logic [31:0]   data_out, data_out_s;
  logic          out_err, out_err_s;
  logic [15:0]   err_cnt;
  logic [1:0]    err_cnt_s;
  logic          err_cnt_clr;

  // clock / reset
  always #5 clk = ~clk;

  pipelined_onehot_mux dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mux_sel(mux_sel), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .out_err(out_err),
    .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  pipelined_onehot_mux #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .mux_sel(mux_sel), .data_in(data_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .data_out(data_out_s), .out_err(out_err_s),
    .err_cnt(err_cnt_s), .err_cnt_clr(err_cnt_clr)
  );

  // scoreboard state
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        acc;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_err;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, data}; data is the selected channel only for exactly one set bit.
  function automatic logic [32:0] ref_beat(input logic [15:0] sel, input logic [511:0] d);
    if ($countones(sel) != 1) return {1'b1, 32'h0};
    for (int k = 0; k < 16; k++) begin
      if (sel[k]) return {1'b0, d[k*32 +: 32]};
    end
    return 33'h0;
  endfunction

  task automatic rand_data();
    for (int k = 0; k < 16; k++) data_in[k*32 +: 32] = $urandom;
  endtask

  task automatic set_chan(input int ch, input logic [31:0] v);
    data_in[ch*32 +: 32] = v;
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic cycle();
    logic [32:0] beat;
    #1;
    if (!out_valid) begin
      chk("idle_data_zero", data_out, 0);
      chk("idle_err_zero", out_err, 0);
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", data_out, prev_data);
      chk("hold_err", out_err, prev_err);
    end
    chk("err_cnt", err_cnt, exp_cnt);
    chk("err_cnt_sat", err_cnt_s, exp_cnt_s);
    if (out_valid && out_ready) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        beat = exp_q.pop_front();
        chk("out_data", data_out, beat[31:0]);
        chk("out_err", out_err, beat[32]);
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_beat(mux_sel, data_in));
    prev_stall = out_valid && !out_ready;
    prev_data  = data_out;
    prev_err   = out_err;
    if (CNT_EN) begin
      if (err_cnt_clr) begin
        exp_cnt   = 0;
        exp_cnt_s = 0;
      end else if (acc && $countones(mux_sel) != 1) begin
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1;
        if (exp_cnt_s != 2'd3) exp_cnt_s = exp_cnt_s + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] vals [3];
    logic [15:0] b_sel [3];
    logic [31:0] b_dat [3];
    int          idx;
    int          budget;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_cnt_clr = 1'b0;
    mux_sel = '0; data_in = '0;
    acc = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_err = 1'b0;
    exp_cnt = '0; exp_cnt_s = '0;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single beat, latency 2
    rand_data(); set_chan(0, 32'hDEADBEEF);
    mux_sel = 16'h0001; in_valid = 1'b1;
    cycle();
    chk("lat_accepted", acc, 1);
    in_valid = 1'b0;
    chk("lat_cycle1_invalid", out_valid, 0);
    cycle();
    chk("lat_cycle2_valid", out_valid, 1);
    chk("lat_data", data_out, 32'hDEADBEEF);
    chk("lat_err", out_err, 0);
    cycle();
    chk("lat_drained", out_valid, 0);

    // back-to-back channels 15, 7, 3
    vals[0] = 32'h0F; vals[1] = 32'h07; vals[2] = 32'h03;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      mux_sel = 16'h0001 << vals[i];
      set_chan(int'(vals[i]), vals[i]);
      in_valid = 1'b1;
      cycle();
      if (i >= 1) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", data_out, vals[i-1]);
      end
    end
    in_valid = 1'b0;
    cycle();
    chk("b2b_last_valid", out_valid, 1);
    chk("b2b_last_data", data_out, vals[2]);
    cycle();
    chk("b2b_done", out_valid, 0);

    // zero and multi-hot selects
    rand_data(); set_chan(0, 32'h11); set_chan(1, 32'h22);
    in_valid = 1'b1; mux_sel = 16'h0000;
    cycle();
    mux_sel = 16'h0003;
    cycle();
    in_valid = 1'b0;
    chk("bad_out_valid", out_valid, 1);
    chk("bad_out_err", out_err, 1);
    chk("bad_data", data_out, 0);
    repeat (3) cycle();
    chk("bad_err_cnt_two", err_cnt, CNT_EN ? 2 : 0);

    // backpressure: 5 stalled cycles with 3 beats offered
    for (int i = 0; i < 3; i++) begin
      b_sel[i] = 16'h0001 << $urandom_range(0, 15);
      b_dat[i] = $urandom;
    end
    out_ready = 1'b0; idx = 0; rand_data();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mux_sel = b_sel[idx];
      for (int k = 0; k < 16; k++) if (b_sel[idx][k]) set_chan(k, b_dat[idx]);
      cycle();
      if (acc) idx++;
    end
    chk("bp_accepted_two", idx, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_data", data_out, b_dat[0]);
    out_ready = 1'b1;
    budget = 20;
    while (idx < 3 && budget > 0) begin
      in_valid = 1'b1; mux_sel = b_sel[idx];
      for (int k = 0; k < 16; k++) if (b_sel[idx][k]) set_chan(k, b_dat[idx]);
      cycle();
      if (acc) idx++;
      budget--;
    end
    chk("bp_third_accepted", idx, 3);
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("bp_drained", exp_q.size(), 0);

    // five invalid beats, then clear with a simultaneous invalid beat
    for (int i = 0; i < 5; i++) begin
      rand_data();
      mux_sel = (i % 2 == 0) ? 16'h0000 : 16'h8001;
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("sat_err_cnt", err_cnt_s, CNT_EN ? 3 : 0);
    chk("wide_err_cnt", err_cnt, CNT_EN ? 7 : 0);
    err_cnt_clr = 1'b1; in_valid = 1'b1; mux_sel = 16'h0300;
    cycle();
    err_cnt_clr = 1'b0; in_valid = 1'b0;
    chk("clr_wins_wide", err_cnt, 0);
    chk("clr_wins_sat", err_cnt_s, 0);
    repeat (3) cycle();

    // reset with two beats in flight
    rand_data(); in_valid = 1'b1;
    mux_sel = 16'h0010; cycle();
    mux_sel = 16'h0400; cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_ready", in_ready, 1);
    chk("rst_async_data", data_out, 0);
    exp_q.delete(); prev_stall = 1'b0; exp_cnt = '0; exp_cnt_s = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("post_rst_no_stale", out_valid, 0);
    end

    // randomized traffic
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      err_cnt_clr = ($urandom_range(0, 31) == 0);
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 3) != 0;
        rand_data();
        case ($urandom_range(0, 9))
          7:       mux_sel = 16'h0000;
          8, 9:    mux_sel = 16'($urandom);
          default: mux_sel = 16'h0001 << $urandom_range(0, 15);
        endcase
      end
      cycle();
    end

    // drain
    in_valid = 1'b0; out_ready = 1'b1; err_cnt_clr = 1'b0;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("final_drain_empty", exp_q.size(), 0);
    cycle();
    chk("final_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_onehot_mux.md
PIPELINED_ONEHOT_MUX -- requirements
Module: pipelined_onehot_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each channel in bits.
REQ-002 SHALL have parameter NUM_CH, default 16, meaning number of input channels (legal range 2..64).
REQ-003 SHALL have parameter ERR_CNT_W, default 16, meaning width of the invalid-select counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block has one clock and reset is asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-008 SHALL have port mux_sel  input  NUM_CH  one-hot channel select, sampled with the beat.
REQ-009 SHALL have port data_in  input  NUM_CH*DATA_W  flat channel bus; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  1  output beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port data_out  output  DATA_W  selected channel data.
REQ-013 SHALL have port out_err  output  1  the current output beat had a non-one-hot select.
REQ-014 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of accepted invalid-select beats.
REQ-015 SHALL have port err_cnt_clr  input  1  synchronous clear of err_cnt.

Function
REQ-016 SHALL accept a beat on any rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL implement two register stages: S1 stores per-group OR-reductions (groups of 4 channels, last group partial), a valid bit and a one-hot check result; S2 stores the final OR-reduction, valid and error flag.
REQ-018 SHALL present an accepted beat on data_out/out_valid exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-019 SHALL advance both stages only when adv = !out_valid || out_ready, and SHALL drive in_ready = adv.
REQ-020 SHALL hold data_out, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one beat per cycle when in_valid=1 and out_ready=1 continuously.
REQ-022 SHALL treat mux_sel as valid only if exactly one bit is set.
REQ-023 SHALL drive data_out to all zeros and out_err to 1 for a beat whose mux_sel is zero or has two or more bits set.
REQ-024 SHALL drive out_err to 0 for a beat with a valid select, and SHALL drive data_out and out_err to 0 whenever out_valid=0.
REQ-025 SHALL increment err_cnt by 1 when an invalid-select beat is accepted at the input, saturating at 2^ERR_CNT_W-1.
REQ-026 SHALL clear err_cnt to 0 on a clock edge with err_cnt_clr=1; clear takes priority over a simultaneous increment.

Reset
REQ-027 SHALL, while rst=1, asynchronously force S1/S2 valid bits, out_valid, data_out, out_err and err_cnt to 0, and drive in_ready to 1.
REQ-028 SHALL discard any in-flight beats on reset; no beat accepted before reset appears after reset.

Configuration
REQ-029 SHALL compile the error counter only when macro PIPELINED_ONEHOT_MUX_ERR_CNT_EN is defined.
REQ-030 SHALL, without PIPELINED_ONEHOT_MUX_ERR_CNT_EN, keep the err_cnt and err_cnt_clr ports, tie err_cnt to 0 and ignore err_cnt_clr; out_err behaviour is unchanged.

Structure
REQ-031 SHALL place the default constants (DATA_W, NUM_CH, ERR_CNT_W defaults, group size 4) in shared package onehot_mux_pkg.
REQ-032 SHALL implement the one-hot check in sub-module onehot_check (input NUM_CH bits; outputs is_onehot, is_zero), instantiated once in S1.

Verification
REQ-033 SHALL cover: defaults, mux_sel=16'h0001, channel 0 = 32'hDEADBEEF, out_ready=1 -> data_out=32'hDEADBEEF, out_err=0, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL cover: back-to-back beats selecting channels 15, 7, 3 (data 32'h0F, 32'h07, 32'h03) -> same order on consecutive cycles, no bubbles.
REQ-035 SHALL cover: mux_sel=16'h0000, then 16'h0003 -> both beats give data_out=0 and out_err=1, and err_cnt=2.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with 3 beats offered -> in_ready=0 once the pipeline is full, data_out held, and all 3 beats delivered in order after out_ready=1.
REQ-037 SHALL cover: ERR_CNT_W=2 with 5 invalid beats -> err_cnt saturates at 3; err_cnt_clr together with an invalid beat -> err_cnt=0.
REQ-038 SHALL cover: rst asserted mid-stream with 2 beats in flight -> out_valid=0 immediately, and no stale beat appears after reset is released.
